// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter: bang-bang phase detector feeding a proportional-integral loop filter
// that produces a saturated phase-interpolator code two clocks after each accepted sample.
module cdr_loop_filter #(
  parameter int SIG_BITS  = 8,
  parameter int INT_BITS  = 12,
  parameter int KI_SHIFT  = 4,
  parameter int KP        = 2,
  parameter int CODE_BITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [SIG_BITS-1:0]  data_samp,
  input  logic signed [SIG_BITS-1:0]  edge_samp,
  input  logic                        hold,
  output logic                        data_bit,
  output logic                        data_valid,
  output logic signed [CODE_BITS-1:0] code,
  output logic                        code_valid
);
  // wide enough that shifted accumulator plus proportional term never wraps
  localparam int WW = INT_BITS + CODE_BITS + 34;
  localparam logic signed [WW-1:0] C_MAX = (WW'(1) <<< (CODE_BITS - 1)) - WW'(1);
  localparam logic signed [WW-1:0] C_MIN = -C_MAX - WW'(1);
  logic                        d_k, e_k, d_prev, have_prev, pd_v;
  logic signed [1:0]           pd, pd_r;
  logic signed [INT_BITS-1:0]  acc, acc_new;
  logic signed [INT_BITS:0]    acc_sum;
  logic signed [WW-1:0]        kp_term, code_sum;
  logic signed [CODE_BITS-1:0] code_sat;
  always_comb begin
    d_k      = $signed(data_samp) >= $signed(SIG_BITS'(0));
    e_k      = $signed(edge_samp) >= $signed(SIG_BITS'(0));
    pd       = (have_prev && d_k != d_prev) ? ((e_k == d_prev) ? 2'sb01 : 2'sb11) : 2'sb00;
    acc_sum  = {acc[INT_BITS-1], acc} + {{(INT_BITS-1){pd_r[1]}}, pd_r};
    acc_new  = hold ? acc
             : (acc_sum[INT_BITS] != acc_sum[INT_BITS-1]) ? {acc_sum[INT_BITS], {(INT_BITS-1){~acc_sum[INT_BITS]}}}
             : acc_sum[INT_BITS-1:0];
    kp_term  = pd_r[1] ? -WW'(KP) : pd_r[0] ? WW'(KP) : '0;
    code_sum = (WW'(acc_new) >>> KI_SHIFT) + kp_term;
    code_sat = (code_sum > C_MAX) ? CODE_BITS'(C_MAX)
             : (code_sum < C_MIN) ? CODE_BITS'(C_MIN)
             : CODE_BITS'(code_sum);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_bit   <= 1'b0;
      data_valid <= 1'b0;
      d_prev     <= 1'b0;
      have_prev  <= 1'b0;
      pd_r       <= '0;
      pd_v       <= 1'b0;
      acc        <= '0;
      code       <= '0;
      code_valid <= 1'b0;
    end else begin
      data_valid <= in_valid;
      pd_v       <= in_valid;
      code_valid <= pd_v;
      if (in_valid) begin
        data_bit  <= d_k;
        d_prev    <= d_k;
        have_prev <= 1'b1;
        pd_r      <= pd;
      end
      if (pd_v) begin
        acc  <= acc_new;
        code <= code_sat;
      end
    end
  end
endmodule

// File: tb/tb_cdr_loop_filter.sv
// tb_cdr_loop_filter: randomized and directed stimulus checked every cycle against
// an arithmetic reference model of the phase detector and loop filter.
module tb_cdr_loop_filter;
  localparam int SB = 8, IB = 12, KS = 4, KP = 2, CB = 8;
  localparam int A_MAX = 2 ** (IB - 1) - 1, A_MIN = -(2 ** (IB - 1));
  localparam int C_MAX = 2 ** (CB - 1) - 1, C_MIN = -(2 ** (CB - 1));
  logic clk = 0, rst_n = 0, in_valid = 0, hold = 0;
  logic signed [SB-1:0] data_samp = '0, edge_samp = '0;
  logic data_bit, data_valid, code_valid;
  logic signed [CB-1:0] code;
  always #5 clk = ~clk;
  cdr_loop_filter #(.SIG_BITS(SB), .INT_BITS(IB), .KI_SHIFT(KS), .KP(KP), .CODE_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_samp(data_samp), .edge_samp(edge_samp),
    .hold(hold), .data_bit(data_bit), .data_valid(data_valid), .code(code), .code_valid(code_valid)
  );
  int n_cmp = 0, n_err = 0;
  int m_acc, m_code, m_db, m_dv, m_cv, m_dprev, m_have, p_v, p_pd;
  bit last_bit;
  function automatic int clamp(input int x, input int lo, input int hi);
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic model_reset;
    m_acc = 0; m_code = 0; m_db = 0; m_dv = 0; m_cv = 0;
    m_dprev = 0; m_have = 0; p_v = 0; p_pd = 0;
  endtask
  // one clock edge of the reference: finish the sample accepted last edge, then accept the new one
  task automatic model_edge;
    int dk, ek;
    m_cv = p_v;
    if (p_v != 0) begin
      if (!hold) m_acc = clamp(m_acc + p_pd, A_MIN, A_MAX);
      m_code = clamp((m_acc >>> KS) + KP * p_pd, C_MIN, C_MAX);
    end
    m_dv = int'(in_valid);
    if (in_valid) begin
      dk = (data_samp >= 0) ? 1 : 0;
      ek = (edge_samp >= 0) ? 1 : 0;
      p_pd = (m_have == 0 || dk == m_dprev) ? 0 : (ek == m_dprev) ? 1 : -1;
      m_db = dk; m_dprev = dk; m_have = 1;
    end
    p_v = int'(in_valid);
  endtask
  task automatic compare_all;
    check("data_valid", int'(data_valid), m_dv);
    check("data_bit", int'(data_bit), m_db);
    check("code_valid", int'(code_valid), m_cv);
    check("code", int'(code), m_code);
    check("acc", int'(dut.acc), m_acc);
  endtask
  task automatic step(input bit v, input logic [7:0] d, input logic [7:0] e, input bit h);
    in_valid = v; data_samp = d; edge_samp = e; hold = h;
    if (v) last_bit = ~d[7];
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask
  task automatic idle(input bit h);
    step(0, 8'h00, 8'h00, h);
  endtask
  // alternating data; edge sign chosen to give pd=+1 (dir>0) or pd=-1
  task automatic pd_run(input int n, input int dir, input bit h);
    logic [7:0] nd, ne;
    for (int i = 0; i < n; i++) begin
      nd = last_bit ? 8'hC0 : 8'h40;
      ne = (dir > 0) ? (last_bit ? 8'h40 : 8'hC0) : nd;
      step(1, nd, ne, h);
    end
  endtask
  initial begin
    model_reset();
    last_bit = 0;
    repeat (2) @(negedge clk);
    check("reset_code", int'(code), 0);
    check("reset_valids", int'(data_valid) + int'(code_valid), 0);
    rst_n = 1;
    pd_run(17, 1, 0);
    idle(0); idle(0);
    check("alt_code", int'(code), 3);
    check("alt_acc", int'(dut.acc), 16);
    repeat (50) step(1, 8'h10, 8'h10, 0);
    idle(0);
    check("const_code", int'(code), 1);
    check("const_acc", int'(dut.acc), 16);
    pd_run(10, -1, 1);
    idle(1);
    check("hold_code", int'(code), -1);
    check("hold_acc", int'(dut.acc), 16);
    pd_run(5, -1, 0);
    idle(0);
    check("resume_acc", int'(dut.acc), 11);
    check("resume_code", int'(code), -2);
    pd_run(5000, 1, 0);
    idle(0);
    check("sat_hi_acc", int'(dut.acc), 2047);
    check("sat_hi_code", int'(code), 127);
    pd_run(5000, -1, 0);
    idle(0);
    check("sat_lo_acc", int'(dut.acc), -2048);
    check("sat_lo_code", int'(code), -128);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), $urandom_range(0, 4) == 0);
    for (int i = 0; i < 30; i++) begin
      step(1, 8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      idle(0); idle(0);
    end
    repeat (7) step(1, 8'($urandom), 8'($urandom), 0);
    rst_n = 0;
    #1;
    check("async_data_bit", int'(data_bit), 0);
    check("async_data_valid", int'(data_valid), 0);
    check("async_code", int'(code), 0);
    check("async_code_valid", int'(code_valid), 0);
    check("async_acc", int'(dut.acc), 0);
    model_reset();
    last_bit = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step(1, 8'hC0, 8'h40, 0);
    check("post_rst_cv_early", int'(code_valid), 0);
    step(1, 8'h40, 8'h40, 0);
    check("post_rst_cv", int'(code_valid), 1);
    check("post_rst_code", int'(code), 0);
    idle(0); idle(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cdr_loop_filter.md
CDR_LOOP_FILTER -- requirements
Module: cdr_loop_filter

Interface
REQ-001 SHALL have parameter SIG_BITS, default 8: width of signed ADC sample inputs.
REQ-002 SHALL have parameter INT_BITS, default 12: width of signed integral accumulator.
REQ-003 SHALL have parameter KI_SHIFT, default 4: arithmetic right shift applied to the accumulator.
REQ-004 SHALL have parameter KP, default 2: proportional gain, a non-negative integer.
REQ-005 SHALL have parameter CODE_BITS, default 8: width of the signed phase-code output.
REQ-006 SHALL have one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports:
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous active-low reset.
- in_valid  input  1: data_samp and edge_samp are valid this cycle.
- data_samp  input  SIG_BITS signed: ADC sample at data phase.
- edge_samp  input  SIG_BITS signed: ADC sample at edge phase.
- hold  input  1: freeze integral accumulator.
- data_bit  output  1: sliced data decision.
- data_valid  output  1: data_bit valid pulse.
- code  output  CODE_BITS signed: phase-interpolator code.
- code_valid  output  1: code updated pulse.

Function
REQ-008 SHALL slice each sample: bit = 1 when sample >= 0, else 0; zero slices to 1.
REQ-009 On a clk edge with in_valid=1 (edge T), the block SHALL register data_bit, assert data_valid for one cycle after T, and store the data slice as d_prev.
REQ-010 At edge T, SHALL compute pd ∈ {-1,0,+1}: 0 if no previous sample since reset; 0 if d_k == d_prev; +1 if d_k != d_prev and e_k == d_prev; -1 if d_k != d_prev and e_k == d_k.
REQ-011 At edge T+1, SHALL update acc <= sat_INT(acc + pd) unless hold=1 at edge T+1, in which case acc is unchanged.
REQ-012 At edge T+1, SHALL register code = sat_CODE((acc_new >>> KI_SHIFT) + KP*pd) and pulse code_valid high for exactly one cycle.
- Latency from input to code is 2 clocks.
REQ-013 The >>> operator SHALL be arithmetic (floor), so -1 >>> 4 = -1.
REQ-014 sat_N SHALL clamp to [-(2^(N-1)), 2^(N-1)-1]; intermediate sums SHALL be computed wide enough to avoid wrap before clamping.
REQ-015 With in_valid=0, data_valid and code_valid SHALL be 0 on the following cycle, and data_bit, code and acc SHALL hold.
REQ-016 Back-to-back in_valid on every cycle SHALL be accepted with no bubbles; each accepted sample SHALL yield exactly one data_valid and one code_valid pulse.
REQ-017 When hold=1, pd SHALL still be computed and SHALL still contribute KP*pd to code.

Reset
REQ-018 rst_n=0 SHALL asynchronously force the following to 0: data_bit, data_valid, code, code_valid, acc, d_prev, the have-previous flag, and all pipeline registers.
REQ-019 Samples in flight when rst_n asserts SHALL be discarded; the first sample after rst_n deasserts SHALL produce pd=0.

Verification
REQ-020 Alternating data and phase error: data_samp alternating 0x40/0xC0 with edge_samp sign equal to the previous data, 17 samples -> first pd=0, then 16× pd=+1; final acc=16, final code=(16>>>4)+2=3.
REQ-021 Constant data: data_samp=0x10 for 50 samples after REQ-020 -> pd=0 throughout; code settles to 1 and acc remains 16.
REQ-022 Saturation: 5000 consecutive pd=+1 samples -> acc clamps at 2047, and code=sat(127+2)=127 with no wrap. Mirror case with pd=-1 -> acc=-2048, code=sat(-128-2)=-128.
REQ-023 Hold: acc=16, hold=1, then 10 pd=-1 samples -> acc stays 16 and code=1-2=-1 on each pulse; hold=0 then resumes decrementing.
REQ-024 Reset mid-stream: drop rst_n during back-to-back samples -> all outputs read 0 immediately without a clock edge; after release, first code_valid shows code=0 (pd=0), and latency remains 2 clocks.
REQ-025 Gapped input: in_valid asserted every third cycle -> one data_valid and one code_valid pulse per sample, each 1 and 2 clocks after acceptance; outputs hold between pulses.
